// File: rtl/fp16_norm_round_if.sv
// fp16_norm_round_if: handshake and data bundle for the FP16 normalise/round stage.
//   Input side : InValid/InReady handshake, InSign, InExp[4:0], InMant[13:0], InSticky.
//   Output side: OutValid/OutReady handshake, Result[15:0], Overflow, Underflow, Inexact.
//   master modport: the producer/consumer around the stage (drives operands, OutReady).
//   slave modport : the stage itself.
interface fp16_norm_round_if;
   logic        InValid;
   logic        InReady;
   logic        InSign;
   logic [4:0]  InExp;
   logic [13:0] InMant;
   logic        InSticky;
   logic        OutValid;
   logic        OutReady;
   logic [15:0] Result;
   logic        Overflow;
   logic        Underflow;
   logic        Inexact;

   modport master (
      output InValid, InSign, InExp, InMant, InSticky, OutReady,
      input  InReady, OutValid, Result, Overflow, Underflow, Inexact
   );

   modport slave (
      input  InValid, InSign, InExp, InMant, InSticky, OutReady,
      output InReady, OutValid, Result, Overflow, Underflow, Inexact
   );
endinterface

// File: rtl/fp16_norm_round.sv
// fp16_norm_round: post-add/sub normalise and round-to-nearest-even stage for binary16.
//   Clk    : rising-edge clock
//   ResetN : asynchronous active-low reset
//   io     : slave side of fp16_norm_round_if
//            in : {InSign, InExp, InMant={carry,hidden,frac[9:0],guard,round}, InSticky}
//            out: Result={sign,exp,frac}, Overflow, Underflow, Inexact
// One operand in flight at a time. The mantissa is shifted one bit per clock until the
// hidden bit is set (or the exponent bottoms out), rounded in one cycle, then loaded into
// the output registers and held until the output handshake.
module fp16_norm_round #(
   parameter int unsigned EXP_W  = 5,
   parameter int unsigned FRAC_W = 10
) (
   input logic                 Clk,
   input logic                 ResetN,
   fp16_norm_round_if.slave    io
);

   localparam int unsigned MantW = FRAC_W + 4;
   localparam int unsigned WordW = EXP_W + FRAC_W + 1;
   localparam logic [EXP_W-1:0] EMax = '1;
   localparam logic [EXP_W-1:0] EOne = EXP_W'(1);

   typedef enum logic [1:0] {StIdle, StNorm, StRound, StDone} state_e;

   state_e             state_q, state_d;
   logic               s_q, s_d;
   logic [EXP_W-1:0]   e_q, e_d;
   logic [MantW-1:0]   m_q, m_d;
   logic               st_q, st_d;
   logic               inf_q, inf_d;
   logic               inx_q, inx_d;
   logic               unf_q, unf_d;
   logic               out_valid_q, out_valid_d;
   logic [WordW-1:0]   result_q, result_d;
   logic               ovf_q, ovf_d;
   logic               out_unf_q, out_unf_d;
   logic               out_inx_q, out_inx_d;

   logic               rnd_up;
   logic               rnd_inx;
   logic [FRAC_W+1:0]  rnd_sum;

   // Round-to-nearest-even on {hidden, frac}; bit FRAC_W+1 of the sum is the carry-out.
   assign rnd_up  = m_q[1] & (m_q[0] | st_q | m_q[2]);
   assign rnd_inx = m_q[1] | m_q[0] | st_q;
   assign rnd_sum = {1'b0, m_q[MantW-2:2]} + {{(FRAC_W + 1){1'b0}}, rnd_up};

   assign io.InReady   = (state_q == StIdle);
   assign io.OutValid  = out_valid_q;
   assign io.Result    = result_q;
   assign io.Overflow  = ovf_q;
   assign io.Underflow = out_unf_q;
   assign io.Inexact   = out_inx_q;

   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      e_d         = e_q;
      m_d         = m_q;
      st_d        = st_q;
      inf_d       = inf_q;
      inx_d       = inx_q;
      unf_d       = unf_q;
      out_valid_d = out_valid_q;
      result_d    = result_q;
      ovf_d       = ovf_q;
      out_unf_d   = out_unf_q;
      out_inx_d   = out_inx_q;

      unique case (state_q)
         StIdle: begin
            if (io.InValid) begin
               s_d     = io.InSign;
               e_d     = io.InExp;
               m_d     = io.InMant;
               st_d    = io.InSticky;
               inx_d   = 1'b0;
               unf_d   = 1'b0;
               inf_d   = (io.InExp == EMax);
               state_d = (io.InExp == EMax) ? StDone : StNorm;
            end
         end

         StNorm: begin
            if (m_q == '0) begin
               e_d     = '0;
               state_d = StRound;
            end else if (m_q[MantW-1]) begin
               m_d  = {1'b0, m_q[MantW-1:1]};
               e_d  = e_q + EOne;
               st_d = st_q | m_q[0];
               if (e_q + EOne == EMax) begin
                  inf_d   = 1'b1;
                  state_d = StDone;
               end
            end else if (!m_q[MantW-2] && (e_q > EOne)) begin
               m_d = {m_q[MantW-2:0], 1'b0};
               e_d = e_q - EOne;
            end else begin
               state_d = StRound;
            end
         end

         StRound: begin
            // After this state e_q holds the packed exponent field and m_q[11:2] the fraction.
            inx_d = rnd_inx;
            unf_d = 1'b0;
            if (rnd_sum[FRAC_W+1]) begin
               m_d[MantW-3:2] = '0;
               if (e_q == EMax - EOne) begin
                  inf_d = 1'b1;
               end else begin
                  e_d = e_q + EOne;
               end
            end else if (rnd_sum[FRAC_W]) begin
               m_d[MantW-3:2] = rnd_sum[FRAC_W-1:0];
               // A subnormal that rounded up into the hidden bit becomes the smallest normal.
               e_d = (e_q == '0) ? EOne : e_q;
            end else begin
               m_d[MantW-3:2] = rnd_sum[FRAC_W-1:0];
               e_d            = '0;
               unf_d          = rnd_inx;
            end
            state_d = StDone;
         end

         StDone: begin
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
               result_d    = inf_q ? {s_q, EMax, {FRAC_W{1'b0}}} : {s_q, e_q, m_q[MantW-3:2]};
               ovf_d       = inf_q;
               out_unf_d   = unf_q & ~inf_q;
               out_inx_d   = inx_q;
            end else if (io.OutReady) begin
               out_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q     <= StIdle;
         s_q         <= 1'b0;
         e_q         <= '0;
         m_q         <= '0;
         st_q        <= 1'b0;
         inf_q       <= 1'b0;
         inx_q       <= 1'b0;
         unf_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         ovf_q       <= 1'b0;
         out_unf_q   <= 1'b0;
         out_inx_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_q         <= s_d;
         e_q         <= e_d;
         m_q         <= m_d;
         st_q        <= st_d;
         inf_q       <= inf_d;
         inx_q       <= inx_d;
         unf_q       <= unf_d;
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         ovf_q       <= ovf_d;
         out_unf_q   <= out_unf_d;
         out_inx_q   <= out_inx_d;
      end
   end

endmodule

// File: tb/tb_fp16_norm_round.sv
// tb_fp16_norm_round: directed vectors with hand-computed binary16 results, flags and
// accept-to-OutValid latency (in clock edges), plus backpressure and mid-operation reset.
module tb_fp16_norm_round;

   logic clk;
   logic rst_n;
   int   n_vec;
   int   n_err;

   fp16_norm_round_if bus ();

   fp16_norm_round dut (
      .Clk    (clk),
      .ResetN (rst_n),
      .io     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one operand (called #1 after a rising edge) and checks the whole transaction.
   task automatic run_vec(input string tag, input logic s, input logic [4:0] e,
                          input logic [13:0] m, input logic st, input logic [15:0] exp_res,
                          input logic exp_ovf, input logic exp_unf, input logic exp_inx,
                          input int exp_lat, input int hold);
      int          lat;
      bit          got;
      logic [15:0] held;
      bus.InSign   = s;
      bus.InExp    = e;
      bus.InMant   = m;
      bus.InSticky = st;
      bus.InValid  = 1'b1;
      bus.OutReady = (hold == 0);
      check({tag, "_rdy"}, 32'(bus.InReady), 32'd1);
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      check({tag, "_busy"}, 32'(bus.InReady), 32'd0);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
         if (bus.OutValid) got = 1'b1;
      end
      check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check({tag, "_res"}, 32'(bus.Result), 32'(exp_res));
      check({tag, "_ovf"}, 32'(bus.Overflow), 32'(exp_ovf));
      check({tag, "_unf"}, 32'(bus.Underflow), 32'(exp_unf));
      check({tag, "_inx"}, 32'(bus.Inexact), 32'(exp_inx));
      held = exp_res;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({tag, "_hold_vld"}, 32'(bus.OutValid), 32'd1);
         check({tag, "_hold_res"}, 32'(bus.Result), 32'(held));
         check({tag, "_hold_rdy"}, 32'(bus.InReady), 32'd0);
      end
      bus.OutReady = 1'b1;
      @(posedge clk);
      #1;
      check({tag, "_vld_drop"}, 32'(bus.OutValid), 32'd0);
      check({tag, "_idle"}, 32'(bus.InReady), 32'd1);
      check({tag, "_res_kept"}, 32'(bus.Result), 32'(exp_res));
   endtask

   initial begin
      bit seen;
      n_vec        = 0;
      n_err        = 0;
      rst_n        = 1'b0;
      bus.InValid  = 1'b0;
      bus.InSign   = 1'b0;
      bus.InExp    = '0;
      bus.InMant   = '0;
      bus.InSticky = 1'b0;
      bus.OutReady = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_vld", 32'(bus.OutValid), 32'd0);
      check("rst_res", 32'(bus.Result), 32'd0);
      check("rst_flags", {29'd0, bus.Overflow, bus.Underflow, bus.Inexact}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rst_rdy", 32'(bus.InReady), 32'd1);

      //       tag       s     e      m         st    result    ov  un  ix  lat hold
      run_vec("carry",   1'b0, 5'd15, 14'h3000, 1'b0, 16'h4200, 0,  0,  0,  4,  0);
      run_vec("left",    1'b0, 5'd15, 14'h0200, 1'b0, 16'h3000, 0,  0,  0,  6,  0);
      run_vec("tie_up",  1'b0, 5'd15, 14'h1FFE, 1'b0, 16'h4000, 0,  0,  1,  3,  0);
      run_vec("tie_dn",  1'b0, 5'd15, 14'h1002, 1'b0, 16'h3C00, 0,  0,  1,  3,  0);
      run_vec("ovf_sh",  1'b1, 5'd30, 14'h2000, 1'b0, 16'hFC00, 1,  0,  0,  2,  0);
      run_vec("ovf_rnd", 1'b0, 5'd30, 14'h1FFF, 1'b0, 16'h7C00, 1,  0,  1,  3,  0);
      run_vec("inf_in",  1'b0, 5'd31, 14'h1000, 1'b0, 16'h7C00, 1,  0,  0,  1,  0);
      run_vec("subn",    1'b0, 5'd2,  14'h0400, 1'b0, 16'h0200, 0,  0,  0,  4,  0);
      run_vec("unf",     1'b0, 5'd1,  14'h0005, 1'b0, 16'h0001, 0,  1,  1,  3,  0);
      run_vec("sub2nrm", 1'b0, 5'd1,  14'h0FFF, 1'b0, 16'h0400, 0,  0,  1,  3,  0);
      run_vec("zero",    1'b1, 5'd9,  14'h0000, 1'b0, 16'h8000, 0,  0,  0,  3,  0);
      run_vec("zero_st", 1'b0, 5'd4,  14'h0000, 1'b1, 16'h0000, 0,  1,  1,  3,  0);
      run_vec("rsh_st",  1'b0, 5'd15, 14'h2003, 1'b0, 16'h4000, 0,  0,  1,  4,  0);
      run_vec("bp",      1'b0, 5'd15, 14'h3000, 1'b0, 16'h4200, 0,  0,  0,  4,  5);

      // Reset in the middle of a long normalisation: no output may appear afterwards.
      bus.InSign   = 1'b0;
      bus.InExp    = 5'd20;
      bus.InMant   = 14'h0001;
      bus.InSticky = 1'b0;
      bus.InValid  = 1'b1;
      @(posedge clk);
      #1;
      bus.InValid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_vld", 32'(bus.OutValid), 32'd0);
      check("mid_rst_res", 32'(bus.Result), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_rdy", 32'(bus.InReady), 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (bus.OutValid) seen = 1'b1;
      end
      check("mid_rst_stale", 32'(seen), 32'd0);
      run_vec("post_rst", 1'b0, 5'd15, 14'h0200, 1'b0, 16'h3000, 0, 0, 0, 6, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fp16_norm_round.md
Name: fp16_norm_round

Overview:
- Post-add/subtract normalise-and-round stage of the FP16 datapath. Sits directly upstream of the final result register and drives the exponent-increment path.
- Takes an unnormalised sign/exponent/extended-mantissa result and normalises it iteratively, one shift per clock.
- Applies round-to-nearest-even and emits a packed IEEE-754 binary16 word with flags.
- Input and output are valid/ready handshakes.

Parameters:
- EXP_W, 5, exponent field width (fixed for FP16; not intended to be overridden)
- FRAC_W, 10, stored fraction width (fixed for FP16)

Ports:
- Clk  input  1  rising-edge clock
- ResetN  input  1  asynchronous active-low reset
- InValid  input  1  input operand valid
- InReady  output  1  block idle and able to accept
- InSign  input  1  result sign
- InExp  input  5  biased exponent of unnormalised result
- InMant  input  14  [13]=carry, [12]=hidden, [11:2]=fraction, [1]=guard, [0]=round
- InSticky  input  1  OR of all bits below round
- OutValid  output  1  Result valid
- OutReady  input  1  downstream accepts Result
- Result  output  16  {sign, exp[4:0], frac[9:0]}
- Overflow  output  1  result saturated to infinity
- Underflow  output  1  result subnormal/zero and inexact
- Inexact  output  1  guard|round|sticky nonzero at rounding

Behaviour:
- Reset (async, ResetN=0):
  - State=IDLE; OutValid=0, Result=16'h0000, all flags 0; InReady=1 once reset deasserts.
  - Reset mid-operation abandons the transaction; no output is produced.
- States: IDLE, NORM, ROUND, DONE. InReady=1 only in IDLE.
- IDLE:
  - Accept on an edge with InValid&InReady; latch the input into working regs {s, e, m[13:0], st}.
  - Next state NORM. If InExp==31, go straight to DONE with infinity and Overflow=1.
- NORM, one action per cycle, in this priority:
  - m==0: go to ROUND (result signed zero, e forced to 0).
  - m[13]=1: right shift one bit, e=e+1, st|=m[0]; stay in NORM. If the new e==31, go to DONE with infinity and Overflow=1.
  - m[12]=0 and e>1: left shift one bit (zero into m[0]), e=e-1; stay in NORM.
  - Otherwise go to ROUND. With m[12]=0 at e<=1 the value is subnormal; exp field output is 0.
- ROUND (one cycle):
  - g=m[1], r=m[0], lsb=m[2]. Round up iff g&(r|st|lsb).
  - Add 1 at m[2] across the 11-bit {m[12:2]}.
  - On carry out of bit 12: mantissa becomes 1.000…, e=e+1. If e reaches 31: infinity, Overflow=1.
  - A subnormal rounding into bit 12 yields exp field 1.
  - Inexact=g|r|st. Underflow=Inexact & (exp field==0).
  - Next state DONE.
- DONE:
  - OutValid=1; Result and flags held stable while OutReady=0.
  - On OutValid&OutReady: return to IDLE; OutValid=0 next cycle. Result and flags keep their last values until the next DONE.
- Latency: OutValid rises 3+N cycles after the accepting edge, where N = number of NORM shifts (0..12).
- Infinity encoding: {s, 5'h1F, 10'h000}.
- Zero result: {s, 5'h00, 10'h000}, flags 0 unless sticky/guard is set.
- No back-to-back acceptance: the earliest next accept is the cycle after the output handshake.

Test Plan:
- Carry case: InSign=0, InExp=15, InMant=14'b11_0000000000_00, sticky 0 → Result=16'h4200 (3.0); OutValid 4 cycles after accept; all flags 0.
- Left normalise: InExp=15, InMant=14'h0200 (bit 9) → 3 left shifts → Result=16'h3000 (0.125); latency 6.
- Tie-to-even with carry: InExp=15, InMant={2'b01, 10'h3FF, 2'b10}, sticky 0 → round up → Result=16'h4000; Inexact=1.
- Overflow: InSign=1, InExp=30, InMant[13]=1 → Result=16'hFC00, Overflow=1.
- Subnormal: InExp=2, InMant=14'h0400 → one shift, stops at e=1 → Result=16'h0200; Underflow=0, Inexact=0.
- Zero: InMant=0, InExp=9, InSign=1 → Result=16'h8000; latency 3.
- Backpressure: hold OutReady=0 for 5 cycles → Result stable, InReady=0.
- Reset: assert ResetN=0 mid-NORM → OutValid=0, InReady=1 after release; no stale output.
